pu_riscv_wb_uart_tx: RTL and testbench

//  Wishbone B3 slave (responder) for the PU-RISCV data bus. It serves the UART-Tx IO region
//  (PMA NA4/IO at 0x8000_1080 and up). Byte writes enter a TX FIFO, which drains through an
//  8N1 serializer onto uart_txd. Status and baud-divisor registers are readable by software.

---
 rtl/pu_riscv_uart_pkg.sv | 26 ++
 rtl/pu_riscv_uart_tx_fifo.sv | 64 ++++++
 rtl/pu_riscv_wb_uart_tx.sv | 203 ++++++++++++++++++++
 tb/tb_pu_riscv_wb_uart_tx.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pu_riscv_uart_pkg.sv
// Shared constants and types for the PU-RISCV Wishbone UART transmitter:
// register offsets, cycle-type codes, serializer states and the reset divisor.
package pu_riscv_uart_pkg;

    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_DIVISOR = 2'd2;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [15:0] DIV_DEFAULT = 16'd434;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_e;

    // Only single (classic or end-of-burst) cycles are served; bursts are refused.
    function automatic logic cti_ok(input logic [2:0] cti);
        return (cti == CTI_CLASSIC) || (cti == CTI_EOB);
    endfunction

endpackage

// File: rtl/pu_riscv_uart_tx_fifo.sv
// Synchronous show-ahead FIFO holding bytes waiting for the UART serializer.
// DEPTH must be a power of two so the pointers wrap on their own.
module pu_riscv_uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_LEVEL = DEPTH[PW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW:0]      level_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (level_q == FULL_LEVEL);
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // NOTE: storage has no reset; only the pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // NOTE: sequential state is assigned with <= so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/pu_riscv_wb_uart_tx.sv
// Wishbone B3 slave for the UART-Tx IO region: byte writes feed a TX FIFO that
// drains through an 8N1 serializer; STATUS and DIVISOR are readable.
module pu_riscv_wb_uart_tx #(
    parameter int          AW          = 32,
    parameter int          DW          = 32,
    parameter int          FIFO_DEPTH  = 16,
    parameter logic [15:0] DIV_DEFAULT = pu_riscv_uart_pkg::DIV_DEFAULT
) (
    input  logic            HCLK,
    input  logic            HRESETn,
    input  logic [AW-1:0]   wb_adr_i,
    input  logic [DW-1:0]   wb_dat_i,
    input  logic [DW/8-1:0] wb_sel_i,
    input  logic            wb_we_i,
    input  logic            wb_cyc_i,
    input  logic            wb_stb_i,
    input  logic [2:0]      wb_cti_i,
    input  logic [1:0]      wb_bte_i,
    output logic [DW-1:0]   wb_dat_o,
    output logic            wb_ack_o,
    output logic            wb_err_o,
    output logic            uart_txd,
    output logic            irq_o
);

    import pu_riscv_uart_pkg::REG_TXDATA;
    import pu_riscv_uart_pkg::REG_STATUS;
    import pu_riscv_uart_pkg::REG_DIVISOR;
    import pu_riscv_uart_pkg::cti_ok;
    import pu_riscv_uart_pkg::tx_state_e;
    import pu_riscv_uart_pkg::IDLE;
    import pu_riscv_uart_pkg::START;
    import pu_riscv_uart_pkg::DATA;
    import pu_riscv_uart_pkg::STOP;

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic            ack_q, err_q, gap_q;
    logic [DW-1:0]   dat_q;
    logic [15:0]     div_q;
    tx_state_e       state_q;
    logic            txd_q, irq_q;
    logic [15:0]     timer_q;
    logic [7:0]      shift_q;
    logic [2:0]      bit_q;

    logic            req;
    logic            push, div_we, resp_err;
    logic [DW-1:0]   rdata;
    logic [15:0]     div_wr;
    logic [31:0]     status_w;
    logic            busy, frame_load;
    logic            fifo_full, fifo_empty;
    logic [7:0]      fifo_rdata;
    logic [LW-1:0]   fifo_level;
    logic            unused_bits;

    assign unused_bits = ^{wb_bte_i, wb_adr_i[AW-1:4], wb_adr_i[1:0],
                           wb_dat_i[DW-1:16], wb_sel_i[DW/8-1:1]};

    // The gap cycle after each termination keeps a held strobe from being served twice.
    assign req = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q & ~gap_q;

    assign busy     = (state_q != IDLE);
    assign status_w = {16'b0, 8'(fifo_level), 5'b0, busy, fifo_empty, fifo_full};
    assign div_wr   = (wb_dat_i[15:0] == 16'd0) ? 16'd1 : wb_dat_i[15:0];

    // NOTE: every always_comb output gets a default first, so no path infers a latch.
    always_comb begin
        push     = 1'b0;
        div_we   = 1'b0;
        resp_err = 1'b0;
        rdata    = '0;
        if (!cti_ok(wb_cti_i)) begin
            resp_err = 1'b1;
        end else begin
            case (wb_adr_i[3:2])
                REG_TXDATA: begin
                    if (wb_we_i) begin
                        if (!wb_sel_i[0] || fifo_full) resp_err = 1'b1;
                        else                           push     = 1'b1;
                    end
                end
                REG_STATUS: begin
                    if (!wb_we_i) rdata = DW'(status_w);
                end
                REG_DIVISOR: begin
                    if (wb_we_i) div_we = 1'b1;
                    else         rdata  = DW'(div_q);
                end
                default: resp_err = 1'b1;
            endcase
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            gap_q <= 1'b0;
            dat_q <= '0;
            div_q <= DIV_DEFAULT;
        end else begin
            ack_q <= req & ~resp_err;
            err_q <= req & resp_err;
            gap_q <= ack_q | err_q;
            dat_q <= (req && !resp_err) ? rdata : '0;
            if (req && div_we) begin
                div_q <= div_wr;
            end
        end
    end

    // A new frame starts from IDLE, or straight out of the last STOP clock when data waits.
    assign frame_load = !fifo_empty &&
                        ((state_q == IDLE) || (state_q == STOP && timer_q == 16'd0));

    pu_riscv_uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (HCLK),
        .rst_n   (HRESETn),
        .push_i  (req & push),
        .data_i  (wb_dat_i[7:0]),
        .pop_i   (frame_load),
        .data_o  (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    // Each bit holds for timer_q counting DIVISOR-1 down to 0, i.e. DIVISOR clocks.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= IDLE;
            txd_q   <= 1'b1;
            irq_q   <= 1'b1;
            timer_q <= '0;
            shift_q <= '0;
            bit_q   <= '0;
        end else begin
            irq_q <= fifo_empty & ~busy;
            unique case (state_q)
                IDLE: begin
                    if (frame_load) begin
                        state_q <= START;
                        txd_q   <= 1'b0;
                        shift_q <= fifo_rdata;
                        timer_q <= div_q - 16'd1;
                    end
                end
                START: begin
                    if (timer_q == 16'd0) begin
                        state_q <= DATA;
                        txd_q   <= shift_q[0];
                        shift_q <= shift_q >> 1;
                        bit_q   <= '0;
                        timer_q <= div_q - 16'd1;
                    end else begin
                        timer_q <= timer_q - 16'd1;
                    end
                end
                DATA: begin
                    if (timer_q == 16'd0) begin
                        timer_q <= div_q - 16'd1;
                        if (bit_q == 3'd7) begin
                            state_q <= STOP;
                            txd_q   <= 1'b1;
                        end else begin
                            txd_q   <= shift_q[0];
                            shift_q <= shift_q >> 1;
                            bit_q   <= bit_q + 3'd1;
                        end
                    end else begin
                        timer_q <= timer_q - 16'd1;
                    end
                end
                STOP: begin
                    if (timer_q == 16'd0) begin
                        if (frame_load) begin
                            state_q <= START;
                            txd_q   <= 1'b0;
                            shift_q <= fifo_rdata;
                            timer_q <= div_q - 16'd1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        timer_q <= timer_q - 16'd1;
                    end
                end
            endcase
        end
    end

    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;
    assign wb_dat_o = dat_q;
    assign uart_txd = txd_q;
    assign irq_o    = irq_q;

endmodule

// File: tb/tb_pu_riscv_wb_uart_tx.sv
// Self-checking bench for pu_riscv_wb_uart_tx: bus responses against register
// rules, and the serial line against an 8N1 waveform model of the expected bytes.
module tb_pu_riscv_wb_uart_tx;

    localparam int          FIFO_DEPTH = 16;
    localparam logic [31:0] BASE       = 32'h8000_1080;
    localparam logic [1:0]  R_TX = 2'd0, R_ST = 2'd1, R_DIV = 2'd2, R_BAD = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] wb_adr = '0, wb_dat = '0;
    logic [3:0]  wb_sel = '0;
    logic        wb_we = 1'b0, wb_cyc = 1'b0, wb_stb = 1'b0;
    logic [2:0]  wb_cti = '0;
    logic [1:0]  wb_bte = '0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o, wb_err_o, uart_txd, irq_o;

    always #5 clk = ~clk;

    pu_riscv_wb_uart_tx #(
        .AW(32), .DW(32), .FIFO_DEPTH(FIFO_DEPTH), .DIV_DEFAULT(16'd434)
    ) dut (
        .HCLK(clk), .HRESETn(rst_n),
        .wb_adr_i(wb_adr), .wb_dat_i(wb_dat), .wb_sel_i(wb_sel), .wb_we_i(wb_we),
        .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_cti_i(wb_cti), .wb_bte_i(wb_bte),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
        .uart_txd(uart_txd), .irq_o(irq_o)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned cyc_cnt  = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Line model: each accepted byte must appear as 0, d0..d7, 1 with mon_div clocks per bit.
    logic [7:0]  exp_q[$];
    int unsigned start_q[$];
    int          mon_div = 434;
    bit          mon_en  = 1'b1;

    initial begin : rx_monitor
        logic [7:0] want, got;
        logic       exp_bit;
        int         mism, nb, k;
        bit         have;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n && uart_txd === 1'b0) begin
                start_q.push_back(cyc_cnt);
                nb   = mon_div;
                have = (exp_q.size() > 0);
                want = have ? exp_q.pop_front() : 8'h00;
                if (!have) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rx_unexpected_frame: frame at cycle %0d, required none", cyc_cnt);
                end
                mism = 0;
                got  = '0;
                for (int i = 0; i < 10 * nb; i++) begin
                    if (i != 0) @(negedge clk);
                    k       = i / nb;
                    exp_bit = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : want[k-1];
                    if (uart_txd !== exp_bit) mism++;
                    if ((i % nb) == (nb / 2) && k >= 1 && k <= 8) got[k-1] = uart_txd;
                end
                if (have) begin
                    check("rx_byte", {24'b0, got}, {24'b0, want});
                    check("rx_waveform_errs", mism, 0);
                end
            end
        end
    end

    function automatic logic [31:0] reg_addr(input logic [1:0] r, input bit rnd);
        logic [31:0] a;
        a = rnd ? ($urandom() & 32'hFFFF_FFF3) : BASE;
        return a | {28'b0, r, 2'b00};
    endfunction

    task automatic wb_xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [2:0] c,
                           output logic got_ack, output logic got_err,
                           output logic [31:0] rd, output int lat);
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = wr; wb_adr = a; wb_dat = d;
        wb_sel = s; wb_cti = c; wb_bte = 2'($urandom_range(0, 3));
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!(wb_ack_o || wb_err_o) && lat < 16);
        if (!(wb_ack_o || wb_err_o)) begin
            n_checks++;
            n_fail++;
            $display("FAIL wb_timeout: no termination after %0d cycles, required 1", lat);
        end
        got_ack = wb_ack_o;
        got_err = wb_err_o;
        rd      = wb_dat_o;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        @(negedge clk);
    endtask

    task automatic wb_wr(input string tag, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [2:0] c, input bit exp_err);
        logic ak, er;
        logic [31:0] rd;
        int lat;
        wb_xfer(1'b1, a, d, s, c, ak, er, rd, lat);
        check({tag, "_resp"}, {30'b0, ak, er}, exp_err ? 32'd1 : 32'd2);
        check({tag, "_lat"}, lat, 1);
    endtask

    task automatic wb_rd(input string tag, input logic [31:0] a, input logic [2:0] c,
                         input bit exp_err, input logic [31:0] exp_dat);
        logic ak, er;
        logic [31:0] rd;
        int lat;
        wb_xfer(1'b0, a, 32'($urandom()), 4'hF, c, ak, er, rd, lat);
        check({tag, "_resp"}, {30'b0, ak, er}, exp_err ? 32'd1 : 32'd2);
        check({tag, "_lat"}, lat, 1);
        if (!exp_err) check({tag, "_dat"}, rd, exp_dat);
    endtask

    task automatic wait_irq(input string tag, input int budget, output int unsigned at);
        int n = 0;
        while (irq_o !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (irq_o !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_idle_timeout: irq_o=%b after %0d cycles, required 1", tag, irq_o, n);
        end
        at = cyc_cnt;
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin : stim
        int unsigned t_idle;
        logic [7:0]  b;
        logic [3:0]  ack_seen;
        int          cur_div, nops, op;
        logic [2:0]  c;

        // Reset state and first STATUS read
        repeat (3) @(negedge clk);
        check("rst_txd", uart_txd, 1);
        check("rst_irq", irq_o, 1);
        check("rst_ack_err", {wb_ack_o, wb_err_o}, 0);
        check("rst_dat", wb_dat_o, 0);
        rst_n = 1'b1;
        wb_rd("status_after_reset", reg_addr(R_ST, 0), 3'b000, 0, 32'h0000_0002);
        wb_rd("div_reset", reg_addr(R_DIV, 0), 3'b111, 0, 32'd434);
        wb_rd("txdata_read", reg_addr(R_TX, 0), 3'b000, 0, 32'h0);

        // One 0x55 frame at 4 clocks per bit; irq rises 41 clocks after the start bit
        wb_wr("div4", reg_addr(R_DIV, 0), 32'd4, 4'hF, 3'b000, 0);
        mon_div = 4;
        start_q.delete();
        exp_q.push_back(8'h55);
        wb_wr("tx55", reg_addr(R_TX, 0), 32'h0000_0055, 4'h1, 3'b000, 0);
        check("irq_low_while_busy", irq_o, 0);
        wait_irq("frame55", 200, t_idle);
        check("frame55_started", start_q.size(), 1);
        if (start_q.size() > 0) check("irq_rise_delay", t_idle - start_q[0], 10 * 4 + 1);

        // DIVISOR=0 stored as 1; held strobe terminates once
        wb_wr("div0", reg_addr(R_DIV, 0), 32'd0, 4'hF, 3'b000, 0);
        wb_rd("div0_readback", reg_addr(R_DIV, 0), 3'b000, 0, 32'd1);
        mon_div = 1;
        exp_q.push_back(8'h3C);
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = reg_addr(R_TX, 0);
        wb_dat = 32'h0000_003C; wb_sel = 4'h1; wb_cti = 3'b000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ack_seen[i] = wb_ack_o | wb_err_o;
            if (i == 2) begin
                wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
            end
        end
        check("held_stb_ack_pattern", ack_seen, 4'b0001);
        wait_irq("held", 100, t_idle);

        // Refused accesses leave the FIFO level unchanged
        wb_wr("div20", reg_addr(R_DIV, 0), 32'd20, 4'hF, 3'b000, 0);
        mon_div = 20;
        for (int i = 0; i < 2; i++) begin
            b = 8'($urandom());
            exp_q.push_back(b);
            wb_wr("lvl_push", reg_addr(R_TX, 0), {24'b0, b}, 4'h1, 3'b000, 0);
        end
        wb_rd("status_lvl1", reg_addr(R_ST, 0), 3'b000, 0, 32'h0000_0104);
        wb_wr("tx_burst_cti", reg_addr(R_TX, 0), 32'h0000_00AA, 4'h1, 3'b010, 1);
        wb_rd("adr_c", reg_addr(R_BAD, 0), 3'b000, 1, 32'h0);
        wb_rd("status_lvl1_again", reg_addr(R_ST, 0), 3'b000, 0, 32'h0000_0104);
        wait_irq("lvl", 800, t_idle);

        // Overfill: one byte in the serializer plus FIFO_DEPTH queued, the next is refused
        start_q.delete();
        for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
            b = 8'($urandom());
            exp_q.push_back(b);
            wb_wr("fill", reg_addr(R_TX, 0), {24'b0, b}, 4'h1, 3'b000, 0);
        end
        wb_rd("status_full", reg_addr(R_ST, 0), 3'b000, 0,
              {16'b0, 8'(FIFO_DEPTH), 8'h05});
        wb_wr("fill_overflow", reg_addr(R_TX, 0), 32'($urandom()) | 32'h1, 4'h1, 3'b000, 1);
        wait_irq("fill", (FIFO_DEPTH + 2) * 200 + 100, t_idle);
        check("fill_frames", start_q.size(), FIFO_DEPTH + 1);
        for (int i = 1; i < start_q.size(); i++) begin
            check("back_to_back_spacing", start_q[i] - start_q[i-1], 10 * 20);
        end

        // Randomized mix of legal and refused accesses
        for (int it = 0; it < 8; it++) begin
            cur_div = $urandom_range(1, 6);
            wb_wr("rnd_div", reg_addr(R_DIV, 1), 32'(cur_div), 4'hF, 3'b111, 0);
            mon_div = cur_div;
            nops = $urandom_range(3, 8);
            for (int j = 0; j < nops; j++) begin
                op = $urandom_range(0, 8);
                c  = ($urandom_range(0, 1) != 0) ? 3'b111 : 3'b000;
                case (op)
                    0, 1, 2: begin
                        b = 8'($urandom());
                        exp_q.push_back(b);
                        wb_wr("rnd_push", reg_addr(R_TX, 1), {24'($urandom()), b},
                              4'($urandom()) | 4'h1, c, 0);
                    end
                    3: wb_wr("rnd_nosel", reg_addr(R_TX, 1), 32'($urandom()),
                             4'($urandom()) & 4'hE, c, 1);
                    4: wb_wr("rnd_badcti", reg_addr(2'($urandom()), 1), 32'($urandom()),
                             4'hF, 3'($urandom_range(1, 6)), 1);
                    5: wb_rd("rnd_adr3", reg_addr(R_BAD, 1), c, 1, 32'h0);
                    6: wb_rd("rnd_div_rd", reg_addr(R_DIV, 1), c, 0, 32'(cur_div));
                    7: wb_rd("rnd_tx_rd", reg_addr(R_TX, 1), c, 0, 32'h0);
                    default: wb_wr("rnd_status_wr", reg_addr(R_ST, 1), 32'($urandom()), 4'hF, c, 0);
                endcase
            end
            wait_irq("rnd", 10 * 6 * 10 + 100, t_idle);
        end

        // Asynchronous reset in the middle of data bit 3 of 0xA5
        wb_wr("div8", reg_addr(R_DIV, 0), 32'd8, 4'hF, 3'b000, 0);
        mon_en = 1'b0;
        wb_wr("txA5", reg_addr(R_TX, 0), 32'h0000_00A5, 4'h1, 3'b000, 0);
        repeat (33) @(negedge clk);
        check("bit3_before_reset", uart_txd, 0);
        #2 rst_n = 1'b0;
        #1;
        check("txd_async_reset", uart_txd, 1);
        check("irq_async_reset", irq_o, 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;
        wb_rd("status_after_midframe_reset", reg_addr(R_ST, 0), 3'b000, 0, 32'h0000_0002);
        wb_rd("div_after_midframe_reset", reg_addr(R_DIV, 0), 3'b000, 0, 32'd434);
        repeat (20) @(negedge clk);
        check("txd_idle_after_reset", uart_txd, 1);

        check("rx_all_frames_seen", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
